// File: rtl/lagd_pll_cfg_ctrl.sv
// Serial PLL config sequencer: shifts one word MSB-first to the PLL, captures readback, pulses cfg-valid, waits for lock.
// Latency: response 2*ClkDiv*CfgWidth+VldCycles+2 cycles after accept with lock already high, up to LockTimeout-1 more.
// Backpressure: one request in flight; cfg_ready_o low until the response handshake, response held until rsp_ready_i.
module lagd_pll_cfg_ctrl #(
    parameter int CfgWidth    = 32,
    parameter int ClkDiv      = 4,
    parameter int VldCycles   = 2,
    parameter int LockTimeout = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [CfgWidth-1:0] cfg_data_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [CfgWidth-1:0] rsp_rdata_o,
    output logic                rsp_timeout_o,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                pll_strb_o,
    output logic                pll_data_o,
    input  logic                pll_data_i,
    output logic                pll_cfg_vld_o,
    input  logic                pll_lock_i
);

    localparam int DivW  = $clog2(ClkDiv) + 1;
    localparam int BitW  = $clog2(CfgWidth) + 1;
    localparam int VldW  = $clog2(VldCycles) + 1;
    localparam int WaitW = $clog2(LockTimeout) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        VLD,
        LOCK_WAIT,
        RESP
    } state_t;

    state_t              state;
    logic [CfgWidth-1:0] tx_sr;
    logic [CfgWidth-1:0] rx_sr;
    logic [DivW-1:0]     div_cnt;
    logic [BitW-1:0]     bit_cnt;
    logic [VldW-1:0]     vld_cnt;
    logic [WaitW-1:0]    wait_cnt;

    // Sequencer: every output is registered and set on the transition into the state that owns it,
    // so the pad signals never glitch and are valid from the first cycle of each state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            tx_sr         <= '0;
            rx_sr         <= '0;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            vld_cnt       <= '0;
            wait_cnt      <= '0;
            cfg_ready_o   <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_timeout_o <= 1'b0;
            busy_o        <= 1'b0;
            pll_strb_o    <= 1'b0;
            pll_data_o    <= 1'b0;
            pll_cfg_vld_o <= 1'b0;
        end else if (abort_i && state != IDLE) begin
            // Abandon everything, including a pending response; back to a clean idle.
            state         <= IDLE;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            vld_cnt       <= '0;
            wait_cnt      <= '0;
            cfg_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_timeout_o <= 1'b0;
            busy_o        <= 1'b0;
            pll_strb_o    <= 1'b0;
            pll_data_o    <= 1'b0;
            pll_cfg_vld_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cfg_ready_o <= 1'b1;
                    if (cfg_valid_i && cfg_ready_o) begin
                        state       <= SHIFT_LO;
                        tx_sr       <= cfg_data_i;
                        rx_sr       <= '0;
                        div_cnt     <= '0;
                        bit_cnt     <= '0;
                        cfg_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        pll_strb_o  <= 1'b0;
                        pll_data_o  <= cfg_data_i[CfgWidth-1];
                    end
                end
                SHIFT_LO: begin
                    pll_data_o <= tx_sr[CfgWidth-1];
                    if (div_cnt == DivW'(ClkDiv - 1)) begin
                        state      <= SHIFT_HI;
                        div_cnt    <= '0;
                        pll_strb_o <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DivW'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt == DivW'(ClkDiv - 1)) begin
                        // Sample readback at the end of the high phase; data only moves while strobe is low.
                        rx_sr      <= {rx_sr[CfgWidth-2:0], pll_data_i};
                        tx_sr      <= {tx_sr[CfgWidth-2:0], 1'b0};
                        bit_cnt    <= bit_cnt + BitW'(1);
                        div_cnt    <= '0;
                        pll_strb_o <= 1'b0;
                        if (bit_cnt == BitW'(CfgWidth - 1)) begin
                            state         <= VLD;
                            vld_cnt       <= '0;
                            pll_data_o    <= 1'b0;
                            pll_cfg_vld_o <= 1'b1;
                        end else begin
                            state      <= SHIFT_LO;
                            pll_data_o <= tx_sr[CfgWidth-2];
                        end
                    end else begin
                        div_cnt <= div_cnt + DivW'(1);
                    end
                end
                VLD: begin
                    if (vld_cnt == VldW'(VldCycles - 1)) begin
                        state         <= LOCK_WAIT;
                        wait_cnt      <= '0;
                        pll_cfg_vld_o <= 1'b0;
                    end else begin
                        vld_cnt <= vld_cnt + VldW'(1);
                    end
                end
                LOCK_WAIT: begin
                    // Lock wins over a timeout that expires in the same cycle.
                    if (pll_lock_i) begin
                        state         <= RESP;
                        rsp_valid_o   <= 1'b1;
                        rsp_rdata_o   <= rx_sr;
                        rsp_timeout_o <= 1'b0;
                    end else if (wait_cnt == WaitW'(LockTimeout - 1)) begin
                        state         <= RESP;
                        rsp_valid_o   <= 1'b1;
                        rsp_rdata_o   <= rx_sr;
                        rsp_timeout_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WaitW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state         <= IDLE;
                        rsp_valid_o   <= 1'b0;
                        rsp_rdata_o   <= '0;
                        rsp_timeout_o <= 1'b0;
                        busy_o        <= 1'b0;
                        cfg_ready_o   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lagd_pll_cfg_ctrl.sv
// Bench for the PLL config sequencer: directed test-plan scenarios plus randomized transactions.
// Expected pad/handshake values come from a cycle-offset model of the protocol timeline.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_lagd_pll_cfg_ctrl;

    localparam int W = 8;
    localparam int D = 2;
    localparam int V = 2;
    localparam int T = 16;
    localparam int S = 2 * D * W;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_rdata;
    logic         rsp_timeout;
    logic         abort;
    logic         busy;
    logic         pll_strb;
    logic         pll_data_out;
    logic         pll_data_in;
    logic         pll_cfg_vld;
    logic         pll_lock;

    int n_chk = 0;
    int n_err = 0;

    lagd_pll_cfg_ctrl #(
        .CfgWidth   (W),
        .ClkDiv     (D),
        .VldCycles  (V),
        .LockTimeout(T)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_data_i   (cfg_data),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_timeout_o(rsp_timeout),
        .abort_i      (abort),
        .busy_o       (busy),
        .pll_strb_o   (pll_strb),
        .pll_data_o   (pll_data_out),
        .pll_data_i   (pll_data_in),
        .pll_cfg_vld_o(pll_cfg_vld),
        .pll_lock_i   (pll_lock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, cfg_ready, strb, data, cfg_vld, rsp_valid, rsp_timeout}
    function automatic logic [6:0] flags();
        return {busy, cfg_ready, pll_strb, pll_data_out, pll_cfg_vld, rsp_valid, rsp_timeout};
    endfunction

    // Cycle in which the response first appears, counted from the accept cycle.
    function automatic int resp_cycle(input int lock_j);
        return S + V + 2 + ((lock_j < T) ? lock_j : (T - 1));
    endfunction

    // Protocol timeline: shift window, cfg-valid window, lock wait, response, idle.
    function automatic logic [6:0] exp_flags(input int k, input logic [W-1:0] word,
                                             input int r, input int h, input logic to);
        int bit_i;
        int ph;
        if (k <= S) begin
            bit_i = (k - 1) / (2 * D);
            ph    = (k - 1) % (2 * D);
            return {1'b1, 1'b0, (ph >= D), word[W-1-bit_i], 3'b000};
        end
        if (k <= S + V) return 7'b1000100;
        if (k < r)      return 7'b1000000;
        if (k <= h)     return {6'b100001, to};
        return 7'b0100000;
    endfunction

    // One request: abort_k/rst_k = -1 means none; abort_k = 0 asserts abort in the accept cycle.
    task automatic run_txn(input string name, input logic [W-1:0] word, input logic [W-1:0] rb,
                           input int lock_j, input int bp, input int abort_k, input int rst_k,
                           input logic hold);
        int r;
        int h;
        int k_end;
        logic to;
        logic [6:0] ef;
        logic [W-1:0] er;
        r  = resp_cycle(lock_j);
        h  = r + bp;
        to = (lock_j >= T);
        if (rst_k >= 1)        k_end = rst_k + 2;
        else if (abort_k >= 1) k_end = abort_k + 1;
        else                   k_end = h + 1;
        cfg_valid = 1'b1;
        cfg_data  = word;
        abort     = (abort_k == 0);
        for (int k = 1; k <= k_end; k++) begin
            tick();
            if (rst_k >= 1 && k == rst_k + 1)           ef = 7'b0000000;
            else if (rst_k >= 1 && k == rst_k + 2)      ef = 7'b0100000;
            else if (abort_k >= 1 && k == abort_k + 1)  ef = 7'b0100000;
            else                                        ef = exp_flags(k, word, r, h, to);
            if (k >= r && k <= h && (abort_k < 1 || k <= abort_k) && (rst_k < 1 || k <= rst_k))
                er = rb;
            else
                er = '0;
            check($sformatf("%s/flags@%0d", name, k), {25'b0, flags()}, {25'b0, ef});
            check($sformatf("%s/rdata@%0d", name, k), {24'b0, rsp_rdata}, {24'b0, er});
            cfg_valid   = hold;
            pll_data_in = (k <= S) ? rb[W-1-(k-1)/(2*D)] : 1'b0;
            pll_lock    = (k == S + V + 1 + lock_j);
            rsp_ready   = (k == h);
            abort       = (k == abort_k);
            rst         = (k == rst_k);
        end
        abort       = 1'b0;
        rst         = 1'b0;
        rsp_ready   = 1'b0;
        pll_lock    = 1'b0;
        pll_data_in = 1'b0;
        cfg_valid   = hold;
    endtask

    task automatic idle_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("%s/flags@%0d", name, i), {25'b0, flags()}, 32'h20);
            check($sformatf("%s/rdata@%0d", name, i), {24'b0, rsp_rdata}, 32'h0);
        end
    endtask

    initial begin
        int lj;
        int bp;
        int mode;
        int ak;
        int rk;
        int hh;
        rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; rsp_ready = 1'b0;
        abort = 1'b0; pll_data_in = 1'b0; pll_lock = 1'b0;
        tick();
        tick();
        check("reset/flags", {25'b0, flags()}, 32'h0);
        check("reset/rdata", {24'b0, rsp_rdata}, 32'h0);
        rst = 1'b0;
        tick();
        check("post_reset/flags", {25'b0, flags()}, 32'h20);

        run_txn("basic",      8'hA5, 8'h00, 0,     0, -1, -1, 1'b0);
        run_txn("readback",   8'hA5, 8'h3C, 0,     1, -1, -1, 1'b0);
        run_txn("timeout",    8'h5A, 8'hC3, T + 4, 0, -1, -1, 1'b0);
        run_txn("lock_last",  8'h81, 8'h7E, T - 1, 2, -1, -1, 1'b0);
        run_txn("bp_hold",    8'h96, 8'h69, 3,     5, -1, -1, 1'b1);
        run_txn("bp_next",    8'h0F, 8'hF0, 0,     0, -1, -1, 1'b0);
        run_txn("abort",      8'hA5, 8'h3C, 0,     0, 15, -1, 1'b0);
        idle_check("abort_idle", 40);
        run_txn("after_abort", 8'hFF, 8'h55, 0,    0, -1, -1, 1'b0);
        run_txn("abort_idle_acc", 8'h33, 8'hCC, 1, 0, 0, -1, 1'b0);
        run_txn("rst_mid",    8'h77, 8'h11, T + 4, 0, -1, S + V + 3, 1'b0);
        idle_check("rst_idle", 30);
        run_txn("abort_resp", 8'h5C, 8'hE1, 0,     4, resp_cycle(0) + 2, -1, 1'b0);
        idle_check("abort_resp_idle", 5);

        for (int n = 0; n < 24; n++) begin
            lj   = $urandom_range(0, T + 2);
            bp   = $urandom_range(0, 5);
            mode = $urandom_range(0, 9);
            hh   = resp_cycle(lj) + bp;
            ak   = -1;
            rk   = -1;
            if (mode == 8) ak = $urandom_range(0, hh);
            if (mode == 9) rk = $urandom_range(1, hh);
            run_txn($sformatf("rand%0d", n), W'($urandom), W'($urandom), lj, bp, ak, rk, 1'b0);
            if (ak >= 1 || rk >= 1) idle_check($sformatf("rand%0d_idle", n), 3);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
